// File: rtl/cmd_pkg.sv
// Shared command/state types for the ALU command responder.
package cmd_pkg;

   localparam int CMD_W      = 3;
   localparam int DATA_W_DEF = 64;
   localparam int DEPTH_DEF  = 8;

   typedef enum logic [CMD_W-1:0] {
      CMD_RST  = 3'd0,
      CMD_INIT = 3'd1,
      CMD_ADD  = 3'd2,
      CMD_SUB  = 3'd3,
      CMD_MULT = 3'd4,
      CMD_DIV  = 3'd5,
      CMD_REM  = 3'd6,
      CMD_HLT  = 3'd7
   } cmd_type_e;

   typedef enum logic [1:0] {
      S_UNINIT = 2'd0,
      S_READY  = 2'd1,
      S_HALTED = 2'd2
   } rsp_state_t;

   function automatic logic cmd_legal(rsp_state_t s, cmd_type_e c);
      logic ok;
      ok = 1'b0;
      unique case (s)
         S_UNINIT: ok = (c == CMD_INIT) || (c == CMD_RST);
         S_READY:  ok = (c != CMD_RST);
         S_HALTED: ok = (c == CMD_RST);
         default:  ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/iter_divider.sv
// Restoring radix-2 unsigned divider, one quotient bit per cycle.
module iter_divider #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_i,
   input  logic [W-1:0] dvd_i,
   input  logic [W-1:0] dvs_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [W-1:0] quo_o,
   output logic [W-1:0] rem_o,
   output logic         div0_o
);
   localparam int NW = $clog2(W + 1);

   logic [W-1:0]  q_q, r_q, d_q;
   logic [NW-1:0] n_q;
   logic          busy_q, done_q, div0_q;
   logic [W-1:0]  tl, nr;
   logic          ge;

   // Partial remainder is shifted left with the next dividend bit; its
   // dropped MSB means the shifted value already exceeds any divisor.
   assign tl = {r_q[W-2:0], q_q[W-1]};
   assign ge = r_q[W-1] | (tl >= d_q);
   assign nr = tl - d_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q    <= '0;
         r_q    <= '0;
         d_q    <= '0;
         n_q    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         div0_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start_i && !busy_q) begin
            q_q    <= dvd_i;
            r_q    <= '0;
            d_q    <= dvs_i;
            n_q    <= NW'(W);
            busy_q <= 1'b1;
            div0_q <= (dvs_i == '0);
         end else if (busy_q) begin
            r_q <= ge ? nr : tl;
            q_q <= {q_q[W-2:0], ge};
            n_q <= n_q - NW'(1);
            if (n_q == NW'(1)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign quo_o  = q_q;
   assign rem_o  = r_q;
   assign div0_o = div0_q;

endmodule

// File: rtl/alu_cmd_responder.sv
// Command responder: pending FIFO, state machine, ALU, divider slot
// and a completion arbiter that issues at most one done per cycle.
module alu_cmd_responder
   import cmd_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ooo_mode_i,
   input  logic              vld_i,
   input  logic [2:0]        cmd_i,
   input  logic [DATA_W-1:0] opd1_i,
   input  logic [DATA_W-1:0] opd2_i,
   output logic              rdy_o,
   output logic              done_o,
   output logic [2:0]        done_cmd_o,
   output logic [DATA_W-1:0] result_o,
   output logic              err_o,
   output logic [3:0]        pending_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      cmd_type_e         cmd;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } ent_t;

   ent_t              mem_q [DEPTH];
   ent_t              head;
   logic [AW-1:0]     wptr_q, rptr_q;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              rdy_q, rdy_d, ooo_q;
   rsp_state_t        st_q, st_d;
   cmd_type_e         dcmd_q, ocmd_q;
   logic              done_q, err_q;
   logic [DATA_W-1:0] res_q, alu_r;
   logic              push, pop, hv, h_legal, h_div;
   logic              div_start, short_go, slot, slot_d, hlt_blk;
   logic              div_busy, div_done, div0;
   logic [DATA_W-1:0] quo, rem;

   assign head      = mem_q[rptr_q];
   assign push      = vld_i & rdy_q;
   assign hv        = (cnt_q != '0);
   assign h_legal   = cmd_legal(st_q, head.cmd);
   assign h_div     = h_legal & ((head.cmd == CMD_DIV) | (head.cmd == CMD_REM));
   assign slot      = div_busy | div_done;
   assign div_start = hv & h_div & ~slot;
   // Divider completion owns the done port; in-order mode also blocks
   // the head for the whole divide.
   assign short_go  = hv & ~h_div & ~div_done & (ooo_q | ~slot);
   assign pop       = div_start | short_go;
   assign cnt_d     = cnt_q + CW'(push) - CW'(pop);
   assign slot_d    = div_start | (slot & ~div_done);
   assign hlt_blk   = (cmd_i == CMD_HLT) & ((cnt_d != '0) | slot_d);
   assign rdy_d     = vld_i & ~push & (cnt_d != CW'(DEPTH)) & ~hlt_blk;
   assign pending_o = 4'(cnt_q) + {3'b000, slot};

   always_comb begin
      alu_r = '0;
      if (h_legal) begin
         unique case (head.cmd)
            CMD_ADD:  alu_r = head.a + head.b;
            CMD_SUB:  alu_r = head.a - head.b;
            CMD_MULT: alu_r = head.a * head.b;
            default:  alu_r = '0;
         endcase
      end
   end

   always_comb begin
      st_d = st_q;
      if (short_go && h_legal) begin
         unique case (head.cmd)
            CMD_INIT: st_d = S_READY;
            CMD_HLT:  st_d = S_HALTED;
            CMD_RST:  st_d = S_UNINIT;
            default:  st_d = st_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= ent_t'{cmd_type_e'(cmd_i), opd1_i, opd2_i};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         rdy_q  <= 1'b0;
         ooo_q  <= 1'b0;
         st_q   <= S_UNINIT;
         dcmd_q <= CMD_RST;
         done_q <= 1'b0;
         ocmd_q <= CMD_RST;
         res_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         if (push) wptr_q <= wptr_q + AW'(1);
         if (pop) rptr_q <= rptr_q + AW'(1);
         cnt_q  <= cnt_d;
         rdy_q  <= rdy_d;
         st_q   <= st_d;
         if (pending_o == 4'd0) ooo_q <= ooo_mode_i;
         if (div_start) dcmd_q <= head.cmd;
         done_q <= div_done | short_go;
         if (div_done) begin
            ocmd_q <= dcmd_q;
            res_q  <= (dcmd_q == CMD_REM) ? rem : quo;
            err_q  <= div0;
         end else if (short_go) begin
            ocmd_q <= head.cmd;
            res_q  <= alu_r;
            err_q  <= ~h_legal;
         end
      end
   end

   iter_divider #(.W(DATA_W)) u_div (
      .clk     (clk),
      .rst     (rst),
      .start_i (div_start),
      .dvd_i   (head.a),
      .dvs_i   (head.b),
      .busy_o  (div_busy),
      .done_o  (div_done),
      .quo_o   (quo),
      .rem_o   (rem),
      .div0_o  (div0)
   );

   assign rdy_o      = rdy_q;
   assign done_o     = done_q;
   assign done_cmd_o = ocmd_q;
   assign result_o   = res_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_alu_cmd_responder.sv
// Directed bench for alu_cmd_responder with a done-event monitor.
module tb_alu_cmd_responder;
   import cmd_pkg::*;

   logic        clk = 1'b0;
   logic        rst, ooo_mode_i, vld_i;
   logic [2:0]  cmd_i;
   logic [63:0] opd1_i, opd2_i;
   logic        rdy_o, done_o, err_o;
   logic [2:0]  done_cmd_o;
   logic [63:0] result_o;
   logic [3:0]  pending_o;

   int vecs = 0;
   int fails = 0;
   int cyc = 0;
   int lat, xc, dc, xdiv;

   logic [2:0]  q_cmd [$];
   logic [63:0] q_res [$];
   logic        q_err [$];
   int          q_cyc [$];

   alu_cmd_responder dut (
      .clk        (clk),
      .rst        (rst),
      .ooo_mode_i (ooo_mode_i),
      .vld_i      (vld_i),
      .cmd_i      (cmd_i),
      .opd1_i     (opd1_i),
      .opd2_i     (opd2_i),
      .rdy_o      (rdy_o),
      .done_o     (done_o),
      .done_cmd_o (done_cmd_o),
      .result_o   (result_o),
      .err_o      (err_o),
      .pending_o  (pending_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst && done_o) begin
         q_cmd.push_back(done_cmd_o);
         q_res.push_back(result_o);
         q_err.push_back(err_o);
         q_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [2:0] c, input logic [63:0] a,
                       input logic [63:0] b, output int l, output int x);
      vld_i  = 1'b1;
      cmd_i  = c;
      opd1_i = a;
      opd2_i = b;
      l = 0;
      @(negedge clk);
      while (!rdy_o && l < 300) begin
         l++;
         @(negedge clk);
      end
      if (!rdy_o) begin
         vecs++;
         fails++;
         $error("FAIL send_timeout: cmd %0d not accepted, got rdy 0 want 1", c);
      end
      x = cyc + 1;
      @(negedge clk);
      vld_i = 1'b0;
   endtask

   task automatic expect_done(input logic [2:0] c, input logic [63:0] r,
                              input logic e, input string tag, output int dcy);
      int w;
      w = 0;
      dcy = 0;
      while (q_cmd.size() == 0 && w < 300) begin
         w++;
         @(negedge clk);
      end
      if (q_cmd.size() == 0) begin
         vecs++;
         fails++;
         $error("FAIL %s_timeout: got no done want cmd %0d", tag, c);
      end else begin
         dcy = q_cyc.pop_front();
         check({tag, "_cmd"}, 64'(q_cmd.pop_front()), 64'(c));
         check({tag, "_res"}, q_res.pop_front(), r);
         check({tag, "_err"}, 64'(q_err.pop_front()), 64'(e));
      end
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (pending_o != 4'd0 && w < 300) begin
         w++;
         @(negedge clk);
      end
      check("drain", 64'(pending_o), 64'd0);
   endtask

   initial begin
      rst = 1'b1;
      ooo_mode_i = 1'b0;
      vld_i = 1'b0;
      cmd_i = '0;
      opd1_i = '0;
      opd2_i = '0;
      repeat (5) @(negedge clk);
      check("rst_rdy", 64'(rdy_o), 64'd0);
      check("rst_done", 64'(done_o), 64'd0);
      check("rst_pend", 64'(pending_o), 64'd0);
      check("rst_res", result_o, 64'd0);
      check("rst_err", 64'(err_o), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      send(CMD_INIT, 64'd0, 64'd0, lat, xc);
      check("init_lat", 64'(lat), 64'd0);
      send(CMD_ADD, 64'd3, 64'd4, lat, xc);
      check("add_lat", 64'(lat), 64'd0);
      expect_done(CMD_INIT, 64'd0, 1'b0, "init", dc);
      expect_done(CMD_ADD, 64'd7, 1'b0, "add", dc);

      send(CMD_SUB, 64'd1, 64'd2, lat, xc);
      expect_done(CMD_SUB, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "sub", dc);
      send(CMD_MULT, 64'h1_0000_0000, 64'h1_0000_0000, lat, xc);
      expect_done(CMD_MULT, 64'd0, 1'b0, "mult", dc);

      drain();
      ooo_mode_i = 1'b1;
      @(negedge clk);
      send(CMD_DIV, 64'd100, 64'd7, lat, xdiv);
      send(CMD_ADD, 64'd1, 64'd1, lat, xc);
      expect_done(CMD_ADD, 64'd2, 1'b0, "ooo_add", dc);
      expect_done(CMD_DIV, 64'd14, 1'b0, "ooo_div", dc);
      check("div_lat", 64'(dc - xdiv), 64'd66);

      drain();
      ooo_mode_i = 1'b0;
      @(negedge clk);
      send(CMD_DIV, 64'd100, 64'd7, lat, xc);
      send(CMD_ADD, 64'd1, 64'd1, lat, xc);
      expect_done(CMD_DIV, 64'd14, 1'b0, "ino_div", dc);
      expect_done(CMD_ADD, 64'd2, 1'b0, "ino_add", dc);

      send(CMD_REM, 64'd9, 64'd0, lat, xc);
      expect_done(CMD_REM, 64'd9, 1'b1, "rem0", dc);
      send(CMD_DIV, 64'd9, 64'd0, lat, xc);
      expect_done(CMD_DIV, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "div0", dc);

      send(CMD_DIV, 64'd50, 64'd5, lat, xc);
      send(CMD_HLT, 64'd0, 64'd0, lat, xc);
      check("hlt_held", 64'(lat > 50), 64'd1);
      expect_done(CMD_DIV, 64'd10, 1'b0, "hlt_div", dc);
      expect_done(CMD_HLT, 64'd0, 1'b0, "hlt", dc);
      send(CMD_ADD, 64'd1, 64'd1, lat, xc);
      expect_done(CMD_ADD, 64'd0, 1'b1, "halt_add", dc);
      send(CMD_RST, 64'd0, 64'd0, lat, xc);
      expect_done(CMD_RST, 64'd0, 1'b0, "rst_cmd", dc);
      send(CMD_ADD, 64'd1, 64'd1, lat, xc);
      expect_done(CMD_ADD, 64'd0, 1'b1, "uninit_add", dc);
      send(CMD_INIT, 64'd0, 64'd0, lat, xc);
      expect_done(CMD_INIT, 64'd0, 1'b0, "reinit", dc);
      send(CMD_ADD, 64'd5, 64'd6, lat, xc);
      expect_done(CMD_ADD, 64'd11, 1'b0, "add2", dc);

      send(CMD_DIV, 64'd1000, 64'd10, lat, xc);
      for (int i = 1; i <= 8; i++) send(CMD_ADD, 64'(i), 64'(i), lat, xc);
      check("full_pend", 64'(pending_o), 64'd9);
      send(CMD_ADD, 64'd100, 64'd1, lat, xc);
      check("full_held", 64'(lat > 20), 64'd1);
      expect_done(CMD_DIV, 64'd100, 1'b0, "full_div", dc);
      for (int i = 1; i <= 8; i++)
         expect_done(CMD_ADD, 64'(2 * i), 1'b0, "full_add", dc);
      expect_done(CMD_ADD, 64'd101, 1'b0, "full_last", dc);

      send(CMD_DIV, 64'd77, 64'd7, lat, xc);
      repeat (20) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      check("abort_nodone", 64'(q_cmd.size()), 64'd0);
      check("abort_pend", 64'(pending_o), 64'd0);
      send(CMD_ADD, 64'd1, 64'd1, lat, xc);
      expect_done(CMD_ADD, 64'd0, 1'b1, "abort_add", dc);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
